// File: rtl/conv_pass_sched_if.sv
// Job/selector/result-write bundle between conv_pass_sched and its surroundings.
// The stall_cnt member exists only when CONV_PASS_SCHED_PERF_EN is defined.
interface conv_pass_sched_if #(
  parameter int RW = 5,
  parameter int CW = 5,
  parameter int AW = 6
);
  logic          start;
  logic          abort;
  logic          res_ready;
  logic          busy;
  logic          done;
  logic          cu_rst;
  logic [RW-1:0] row_num;
  logic [CW-1:0] col_sel;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
`ifdef CONV_PASS_SCHED_PERF_EN
  logic [31:0]   stall_cnt;
`endif

  // master: job issuer / result buffer side
  modport master (
    output start,
    output abort,
    output res_ready,
    input  busy,
    input  done,
    input  cu_rst,
    input  row_num,
    input  col_sel,
    input  wr_en,
`ifdef CONV_PASS_SCHED_PERF_EN
    input  stall_cnt,
`endif
    input  wr_addr
  );

  // slave: the scheduler itself
  modport slave (
    input  start,
    input  abort,
    input  res_ready,
    output busy,
    output done,
    output cu_rst,
    output row_num,
    output col_sel,
    output wr_en,
`ifdef CONV_PASS_SCHED_PERF_EN
    output stall_cnt,
`endif
    output wr_addr
  );
endinterface

// File: rtl/conv_pass_sched.sv
// Pass sequencer for a single-layer convolution datapath: one pass per output row-half.
// Optional CONV_PASS_SCHED_PERF_EN adds a saturating stall-cycle counter (bus.stall_cnt).
module conv_pass_sched #(
  parameter int D = 1,
  parameter int S = 5,
  parameter int H = 32,
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst,
  conv_pass_sched_if.slave bus
);
  localparam int OH       = H - S + 1;
  localparam int OW       = W - S + 1;
  localparam int NCU      = OW / 2;
  localparam int CU_LAT   = D * S * S + 2;
  localparam int NPASS    = 2 * OH;
  localparam int RW       = ($clog2(OH) > 1) ? $clog2(OH) : 1;
  localparam int CW       = ($clog2(OW) > 1) ? $clog2(OW) : 1;
  localparam int AW       = ($clog2(NPASS) > 1) ? $clog2(NPASS) : 1;
  localparam int CNTW     = ($clog2(CU_LAT) > 1) ? $clog2(CU_LAT) : 1;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(CU_LAT - 1);
  localparam logic [RW-1:0]   LAST_ROW = RW'(OH - 1);

  if (OW < 2 || (OW % 2) != 0 || S > H || S > W) begin : g_param_err
    $error("conv_pass_sched: need OW even and >= 2, S <= H, S <= W");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_WRITE,
    ST_CLR,
    ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [RW-1:0]   row_q, row_d;
  logic            col_hi_q, col_hi_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            cu_rst_q, cu_rst_d;
  logic            wr_en_q, wr_en_d;
  logic [CW-1:0]   col_sel_q, col_sel_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [RW:0]     addr_full;
  logic            last_pass;
  logic            job_active;

  assign last_pass  = (row_q == LAST_ROW) && col_hi_q;
  assign job_active = (state_q == ST_RUN) || (state_q == ST_WRITE) || (state_q == ST_CLR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      row_q     <= '0;
      col_hi_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cu_rst_q  <= 1'b1;
      wr_en_q   <= 1'b0;
      col_sel_q <= '0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      col_hi_q  <= col_hi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cu_rst_q  <= cu_rst_d;
      wr_en_q   <= wr_en_d;
      col_sel_q <= col_sel_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  // Next state plus the pass pointers and compute-window counter that travel with it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    col_hi_d = col_hi_q;
    if (bus.abort && job_active) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      row_d    = '0;
      col_hi_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d  = ST_RUN;
            cnt_d    = '0;
            row_d    = '0;
            col_hi_d = 1'b0;
          end
        end
        ST_RUN: begin
          if (cnt_q == LAST_CNT) begin
            state_d = ST_WRITE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
        ST_WRITE: begin
          if (bus.res_ready) begin
            state_d = ST_CLR;
          end
        end
        ST_CLR: begin
          cnt_d = '0;
          if (last_pass) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            if (col_hi_q) begin
              col_hi_d = 1'b0;
              row_d    = row_q + RW'(1);
            end else begin
              col_hi_d = 1'b1;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_comb begin
    busy_d   = 1'b0;
    done_d   = 1'b0;
    cu_rst_d = 1'b1;
    wr_en_d  = 1'b0;
    case (state_d)
      ST_RUN: begin
        busy_d   = 1'b1;
        cu_rst_d = 1'b0;
      end
      ST_WRITE: begin
        busy_d   = 1'b1;
        cu_rst_d = 1'b0;
        wr_en_d  = 1'b1;
      end
      ST_CLR:  busy_d = 1'b1;
      ST_DONE: done_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
    col_sel_d = col_hi_d ? CW'(NCU) : '0;
    addr_full = {row_d, col_hi_d};
    wr_addr_d = addr_full[AW-1:0];
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.cu_rst  = cu_rst_q;
  assign bus.row_num = row_q;
  assign bus.col_sel = col_sel_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;

`ifdef CONV_PASS_SCHED_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == ST_IDLE && bus.start) begin
      stall_cnt_d = '0;
    end else if (state_q == ST_WRITE && !bus.res_ready && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule
